// File: rtl/timer_irq_master.sv
// rtl/timer_irq_master.sv - register-bus initiator that programs the fabric timer and services its interrupt (option: TIMER_SNAPSHOT_EN)
module timer_irq_master #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic        cmd_start,
    input  logic        cmd_stop,
    input  logic [31:0] cfg_overflow,
    input  logic [31:0] cfg_compare,
    input  logic [3:0]  cfg_ctrl,
    output logic        busy,
    output logic        armed,
    output logic        evt_valid,
    output logic        evt_overflow,
    output logic        evt_compare,
    output logic [31:0] evt_count,
    output logic        missed_irq,
    output logic        bus_write_en,
    output logic        bus_read_en,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_write_data,
    input  logic [31:0] bus_read_data,
    input  logic        fabint
);

    localparam logic [31:0] OFF_OVF   = 32'h00;
    localparam logic [31:0] OFF_VALUE = 32'h04;
    localparam logic [31:0] OFF_CTRL  = 32'h08;
    localparam logic [31:0] OFF_CMP   = 32'h0C;
    localparam logic [31:0] OFF_STAT  = 32'h10;

`ifdef TIMER_SNAPSHOT_EN
    localparam bit SNAPSHOT = 1'b1;
`else
    localparam bit SNAPSHOT = 1'b0;
`endif

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_CTRL0,
        S_WR_OVF,
        S_WR_CMP,
        S_WR_CTRL,
        S_ARMED,
        S_WR_STOP,
        S_RD_STAT,
        S_WAIT_STAT,
        S_EVT
`ifdef TIMER_SNAPSHOT_EN
        ,
        S_RD_CNT,
        S_WAIT_CNT
`endif
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] ovf_q;
    logic [31:0] cmp_q;
    logic [3:0]  ctrl_q;
    logic        pending;
    logic [1:0]  stat_q;

    logic        write_en_d;
    logic        read_en_d;
    logic [31:0] addr_d;
    logic [31:0] write_data_d;
    logic        start_accept;
    logic        svc_now;

    // States in which the timer is running and interrupts are being watched
    function automatic logic in_service(input state_t s);
        logic r;
        r = 1'b0;
        case (s)
            S_ARMED, S_RD_STAT, S_WAIT_STAT, S_EVT: r = 1'b1;
`ifdef TIMER_SNAPSHOT_EN
            S_RD_CNT, S_WAIT_CNT: r = 1'b1;
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Next-state decode; stop beats start, commands only honoured in IDLE/ARMED
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (cmd_start && !cmd_stop) state_next = S_WR_CTRL0;
            end
            S_WR_CTRL0: state_next = S_WR_OVF;
            S_WR_OVF:   state_next = S_WR_CMP;
            S_WR_CMP:   state_next = S_WR_CTRL;
            S_WR_CTRL:  state_next = S_ARMED;
            S_ARMED: begin
                if (cmd_stop)               state_next = S_WR_STOP;
                else if (cmd_start)         state_next = S_WR_CTRL0;
                else if (pending || fabint) state_next = S_RD_STAT;
            end
            S_WR_STOP: state_next = S_IDLE;
            S_RD_STAT: state_next = S_WAIT_STAT;
            S_WAIT_STAT: begin
`ifdef TIMER_SNAPSHOT_EN
                state_next = S_RD_CNT;
`else
                state_next = S_EVT;
`endif
            end
`ifdef TIMER_SNAPSHOT_EN
            S_RD_CNT:   state_next = S_WAIT_CNT;
            S_WAIT_CNT: state_next = S_EVT;
`endif
            S_EVT:   state_next = S_ARMED;
            default: state_next = S_IDLE;
        endcase
    end

    // Bus strobe/address/data for the state being entered, so the bus pins come straight from flops
    always_comb begin
        write_en_d   = 1'b0;
        read_en_d    = 1'b0;
        addr_d       = 32'd0;
        write_data_d = 32'd0;
        case (state_next)
            S_WR_CTRL0, S_WR_STOP: begin
                write_en_d = 1'b1;
                addr_d     = BASE_ADDR + OFF_CTRL;
            end
            S_WR_OVF: begin
                write_en_d   = 1'b1;
                addr_d       = BASE_ADDR + OFF_OVF;
                write_data_d = ovf_q;
            end
            S_WR_CMP: begin
                write_en_d   = 1'b1;
                addr_d       = BASE_ADDR + OFF_CMP;
                write_data_d = cmp_q;
            end
            S_WR_CTRL: begin
                write_en_d   = 1'b1;
                addr_d       = BASE_ADDR + OFF_CTRL;
                write_data_d = {28'd0, ctrl_q};
            end
            S_RD_STAT: begin
                read_en_d = 1'b1;
                addr_d    = BASE_ADDR + OFF_STAT;
            end
`ifdef TIMER_SNAPSHOT_EN
            S_RD_CNT: begin
                read_en_d = 1'b1;
                addr_d    = BASE_ADDR + OFF_VALUE;
            end
`endif
            default: ;
        endcase
    end

    // Qualifiers for command acceptance and live interrupt observation
    always_comb begin
        start_accept = (state_next == S_WR_CTRL0);
        svc_now      = fabint && in_service(state) && !start_accept && (state_next != S_WR_STOP);
    end

    // State, registered outputs, config latch and interrupt bookkeeping
    always_ff @(posedge pclk) begin
        if (reset) begin
            state          <= S_IDLE;
            busy           <= 1'b0;
            armed          <= 1'b0;
            evt_valid      <= 1'b0;
            evt_overflow   <= 1'b0;
            evt_compare    <= 1'b0;
            evt_count      <= 32'd0;
            missed_irq     <= 1'b0;
            bus_write_en   <= 1'b0;
            bus_read_en    <= 1'b0;
            bus_addr       <= 32'd0;
            bus_write_data <= 32'd0;
            ovf_q          <= 32'd0;
            cmp_q          <= 32'd0;
            ctrl_q         <= 4'd0;
            pending        <= 1'b0;
            stat_q         <= 2'd0;
        end else begin
            state          <= state_next;
            bus_write_en   <= write_en_d;
            bus_read_en    <= read_en_d;
            bus_addr       <= addr_d;
            bus_write_data <= write_data_d;
            busy           <= (state_next != S_IDLE) && (state_next != S_ARMED);
            armed          <= in_service(state_next);
            evt_valid      <= (state_next == S_EVT);

            if (start_accept) begin
                ovf_q      <= cfg_overflow;
                cmp_q      <= cfg_compare;
                ctrl_q     <= cfg_ctrl;
                pending    <= 1'b0;
                missed_irq <= 1'b0;
            end else if (state_next == S_WR_STOP) begin
                pending <= 1'b0;
            end else begin
                if (svc_now && pending) missed_irq <= 1'b1;
                if (state == S_WAIT_STAT) pending <= 1'b0;
                else if (svc_now)         pending <= 1'b1;
            end

            if (state == S_WAIT_STAT) stat_q <= bus_read_data[1:0];

            if (state_next == S_EVT) begin
                evt_overflow <= (state == S_WAIT_STAT) ? bus_read_data[0] : stat_q[0];
                evt_compare  <= (state == S_WAIT_STAT) ? bus_read_data[1] : stat_q[1];
                evt_count    <= SNAPSHOT ? bus_read_data : 32'd0;
            end
        end
    end

endmodule
